aes_round_ctrl: RTL and testbench

Round sequencer for the AES-128 encryption datapath. It loads a 128-bit plaintext, then drives the existing stage modules (SubBytes, ShiftRows, Mixcolumn_module, AddRoundKey) through their start/done handshakes in AES round order, capturing each stage's result into an internal state register. It publishes the round index for the key-schedule block and signals completion with a one-cycle `done` pulse, with the ciphertext held on `ct`.

---
 rtl/aes_pkg.sv | 22 ++
 rtl/aes_stage_mux.sv | 55 +++++
 rtl/aes_round_ctrl.sv | 144 ++++++++++++++
 tb/tb_aes_round_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 round sequencer and its stage decoder.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FIN   = 2'd3
    } ctrl_state_e;

    typedef logic [1:0] stage_t;

    localparam stage_t SUB   = 2'd0;
    localparam stage_t SHIFT = 2'd1;
    localparam stage_t MIX   = 2'd2;
    localparam stage_t ARK   = 2'd3;

endpackage

// File: rtl/aes_stage_mux.sv
// Decodes the sequencer's current stage into one-hot start pulses and selects
// that stage's done flag and result, so the FSM never sees per-stage wiring.
module aes_stage_mux
    import aes_pkg::*;
(
    input  logic [1:0]   stage_i,
    input  logic         issue_i,
    input  logic         sub_done_i,
    input  logic         shift_done_i,
    input  logic         mix_done_i,
    input  logic         ark_done_i,
    input  logic [127:0] sub_res_i,
    input  logic [127:0] shift_res_i,
    input  logic [127:0] mix_res_i,
    input  logic [127:0] ark_res_i,
    output logic         sub_start_o,
    output logic         shift_start_o,
    output logic         mix_start_o,
    output logic         ark_start_o,
    output logic         sel_done_o,
    output logic [127:0] sel_res_o
);

    always_comb begin
        sub_start_o   = 1'b0;
        shift_start_o = 1'b0;
        mix_start_o   = 1'b0;
        ark_start_o   = 1'b0;
        sel_done_o    = 1'b0;
        sel_res_o     = '0;
        case (stage_i)
            SUB: begin
                sub_start_o = issue_i;
                sel_done_o  = sub_done_i;
                sel_res_o   = sub_res_i;
            end
            SHIFT: begin
                shift_start_o = issue_i;
                sel_done_o    = shift_done_i;
                sel_res_o     = shift_res_i;
            end
            MIX: begin
                mix_start_o = issue_i;
                sel_done_o  = mix_done_i;
                sel_res_o   = mix_res_i;
            end
            default: begin
                ark_start_o = issue_i;
                sel_done_o  = ark_done_i;
                sel_res_o   = ark_res_i;
            end
        endcase
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: walks SubBytes/ShiftRows/MixColumns/AddRoundKey in round order.
// Optional per-stage watchdog is built when AES_CTRL_TIMEOUT_EN is defined.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR             = AES_NR,
    parameter int TIMEOUT_CYCLES = 16384
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] pt,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [127:0] ct,
    output logic [3:0]   round_idx,
    output logic         sub_start,
    output logic         shift_start,
    output logic         mix_start,
    output logic         ark_start,
    input  logic         sub_done,
    input  logic         shift_done,
    input  logic         mix_done,
    input  logic         ark_done,
    input  logic [127:0] sub_res,
    input  logic [127:0] shift_res,
    input  logic [127:0] mix_res,
    input  logic [127:0] ark_res
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    ctrl_state_e state_q, state_d;
    stage_t      stage_q, stage_d;
    logic [3:0]  round_q, round_d;
    aes_state_t  ct_q, ct_d;
    logic        sel_done;
    aes_state_t  sel_res;
    logic        timeout;

    aes_stage_mux u_mux (
        .stage_i       (stage_q),
        .issue_i       (state_q == ST_ISSUE),
        .sub_done_i    (sub_done),
        .shift_done_i  (shift_done),
        .mix_done_i    (mix_done),
        .ark_done_i    (ark_done),
        .sub_res_i     (sub_res),
        .shift_res_i   (shift_res),
        .mix_res_i     (mix_res),
        .ark_res_i     (ark_res),
        .sub_start_o   (sub_start),
        .shift_start_o (shift_start),
        .mix_start_o   (mix_start),
        .ark_start_o   (ark_start),
        .sel_done_o    (sel_done),
        .sel_res_o     (sel_res)
    );

`ifdef AES_CTRL_TIMEOUT_EN
    localparam logic [14:0] WDOG_LAST = 15'(TIMEOUT_CYCLES - 1);

    logic [14:0] wdog_q, wdog_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wdog_q <= '0;
        else        wdog_q <= wdog_d;
    end

    always_comb begin
        wdog_d = wdog_q;
        if (state_q == ST_ISSUE)     wdog_d = '0;
        else if (state_q == ST_WAIT) wdog_d = wdog_q + 15'd1;
    end

    // Fires on the last WAIT cycle in which the stage could still have answered.
    assign timeout = (state_q == ST_WAIT) && !sel_done && (wdog_q == WDOG_LAST);
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            stage_q <= ARK;
            round_q <= '0;
            ct_q    <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            round_q <= round_d;
            ct_q    <= ct_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        round_d = round_q;
        ct_d    = ct_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ct_d    = pt;
                    round_d = '0;
                    stage_d = ARK;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (sel_done) begin
                    ct_d    = sel_res;
                    state_d = ST_ISSUE;
                    case (stage_q)
                        SUB:     stage_d = SHIFT;
                        SHIFT:   stage_d = (round_q == LAST_ROUND) ? ARK : MIX;
                        MIX:     stage_d = ARK;
                        default: begin
                            if (round_q == LAST_ROUND) begin
                                state_d = ST_FIN;
                            end else begin
                                round_d = round_q + 4'd1;
                                stage_d = SUB;
                            end
                        end
                    endcase
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FIN);
    assign err       = timeout;
    assign ct        = ct_q;
    assign round_idx = round_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: table of directed runs plus hand-written
// sequences for known-answer, busy/held start, mid-run reset and watchdog cases.
module tb_aes_round_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] pt = '0;
    logic         busy, done, err;
    logic [127:0] ct;
    logic [3:0]   round_idx;
    logic         sub_start, shift_start, mix_start, ark_start;
    logic         sub_done, shift_done, mix_done, ark_done;
    logic [127:0] sub_res, shift_res, mix_res, ark_res;

    int checks = 0;
    int failures = 0;

    bit   mode = 1'b0;          // 0: synthetic stages, 1: real AES stages
    int   lat [4];
    int   cnt [4];
    logic spur_mix = 1'b0;
    logic [127:0] rk [0:10];
    logic [31:0]  w [0:43];

    always #5 clk = ~clk;

    aes_round_ctrl #(.NR(10), .TIMEOUT_CYCLES(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pt(pt),
        .busy(busy), .done(done), .err(err), .ct(ct), .round_idx(round_idx),
        .sub_start(sub_start), .shift_start(shift_start),
        .mix_start(mix_start), .ark_start(ark_start),
        .sub_done(sub_done), .shift_done(shift_done),
        .mix_done(mix_done), .ark_done(ark_done),
        .sub_res(sub_res), .shift_res(shift_res),
        .mix_res(mix_res), .ark_res(ark_res)
    );

    // ---------------- AES reference helpers ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        logic [7:0] pw  = x;
        logic [7:0] e   = 8'hfe;
        logic [7:0] s, r;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) inv = gmul(inv, pw);
            pw = gmul(pw, pw);
        end
        s = inv;
        r = inv;
        for (int k = 0; k < 4; k++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(gb(s, i));
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = gb(s, r + 4*((c+r)%4));
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
            o[127-8*(4*c)   -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[127-8*(4*c+1) -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[127-8*(4*c+3) -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    // Stage behaviour: which 0..3 = SUB, SHIFT, MIX, ARK
    function automatic logic [127:0] stg(input int which, input logic [127:0] s,
                                         input logic [3:0] r, input bit m);
        if (m) begin
            case (which)
                0:       return sub_bytes(s);
                1:       return shift_rows(s);
                2:       return mix_cols(s);
                default: return s ^ rk[r];
            endcase
        end
        case (which)
            0:       return (s + 128'h1) ^ 128'h11;
            1:       return {s[119:0], s[127:120]} ^ 128'h22;
            2:       return s ^ {s[126:0], s[127]} ^ 128'h33;
            default: return s ^ ({124'h0, r} * 128'h0123456789abcdeffedcba9876543210) ^ 128'h44;
        endcase
    endfunction

    function automatic logic [127:0] model(input logic [127:0] p, input bit m);
        logic [127:0] s;
        s = stg(3, p, 4'd0, m);
        for (int r = 1; r <= 9; r++) begin
            s = stg(0, s, 4'(r), m);
            s = stg(1, s, 4'(r), m);
            s = stg(2, s, 4'(r), m);
            s = stg(3, s, 4'(r), m);
        end
        s = stg(0, s, 4'd10, m);
        s = stg(1, s, 4'd10, m);
        return stg(3, s, 4'd10, m);
    endfunction

    // ---------------- stage models ----------------
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) cnt[i] <= 0;
        end else begin
            if (sub_start)   cnt[0] <= lat[0]; else if (cnt[0] != 0) cnt[0] <= cnt[0] - 1;
            if (shift_start) cnt[1] <= lat[1]; else if (cnt[1] != 0) cnt[1] <= cnt[1] - 1;
            if (mix_start)   cnt[2] <= lat[2]; else if (cnt[2] != 0) cnt[2] <= cnt[2] - 1;
            if (ark_start)   cnt[3] <= lat[3]; else if (cnt[3] != 0) cnt[3] <= cnt[3] - 1;
        end
    end

    assign sub_done   = (cnt[0] == 1);
    assign shift_done = (cnt[1] == 1);
    assign mix_done   = (cnt[2] == 1) | spur_mix;
    assign ark_done   = (cnt[3] == 1);
    assign sub_res    = stg(0, ct, round_idx, mode);
    assign shift_res  = stg(1, ct, round_idx, mode);
    assign mix_res    = stg(2, ct, round_idx, mode);
    assign ark_res    = stg(3, ct, round_idx, mode);

    // ---------------- checking ----------------
    task automatic chk_v(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    int r_done_cyc, r_done_cnt, r_max;
    bit r_busy1, r_busy2, r_mix10, r_rbad;
    int r_starts [4];

    task automatic set_lat(input int a, input int b, input int c, input int d);
        lat[0] = a; lat[1] = b; lat[2] = c; lat[3] = d;
    endtask

    // One encryption; cycle n is the n-th cycle after the edge that samples start.
    task automatic run(input logic [127:0] p, input bit spur_en, input int pulse_at);
        int prev = 0;
        bit sub_act = 1'b0;
        r_done_cyc = -1; r_done_cnt = 0; r_max = 0;
        r_busy1 = 1'b1; r_busy2 = 1'b1; r_mix10 = 1'b0; r_rbad = 1'b0;
        for (int i = 0; i < 4; i++) r_starts[i] = 0;
        start = 1'b1;
        pt = p;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 3000; n++) begin
            if (done) begin
                r_done_cnt++;
                if (r_done_cyc < 0) r_done_cyc = n;
            end
            if (r_done_cyc > 0 && n == r_done_cyc + 1) r_busy1 = busy;
            if (r_done_cyc > 0 && n == r_done_cyc + 2) r_busy2 = busy;
            if (mix_start && round_idx == 4'd10) r_mix10 = 1'b1;
            if (int'(round_idx) != prev && int'(round_idx) != prev + 1) r_rbad = 1'b1;
            prev = int'(round_idx);
            if (prev > r_max) r_max = prev;
            r_starts[0] += int'(sub_start);
            r_starts[1] += int'(shift_start);
            r_starts[2] += int'(mix_start);
            r_starts[3] += int'(ark_start);
            if (sub_start) sub_act = 1'b1;
            else if (sub_done) sub_act = 1'b0;
            spur_mix = spur_en & sub_act;
            start = (n == pulse_at);
            pt = (n == pulse_at) ? ~p : p;
            if (r_done_cyc > 0 && n >= r_done_cyc + 2) break;
            @(negedge clk);
        end
        start = 1'b0;
        spur_mix = 1'b0;
    endtask

    typedef struct {
        logic [127:0] pt;
        int ks, ksh, km, ka;
        bit spur;
        int pulse_at;
        int exp_cyc;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [127:0] key, p;
        int d1, d2, dc, found;
        bit b82, b83;

        set_lat(1, 1, 1, 1);
        vecs[0] = '{128'h0, 1, 1, 1, 1, 1'b0, 0, 81};
        vecs[1] = '{128'h0123456789abcdeffedcba9876543210, 1, 1, 1, 1, 1'b0, 10, 81};
        vecs[2] = '{{128{1'b1}}, 3, 1, 7, 1, 1'b1, 0, 155};
        vecs[3] = '{128'h00112233445566778899aabbccddeeff, 2, 2, 2, 2, 1'b0, 121, 121};
        vecs[4] = '{128'hdeadbeefcafef00d0badc0de12345678, 1, 4, 1, 2, 1'b0, 0, 122};

        key = 128'h000102030405060708090a0b0c0d0e0f;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

        // Reset state
        repeat (2) @(negedge clk);
        chk_i("reset_busy_done_err", int'({busy, done, err}), 0);
        chk_v("reset_ct", ct, 128'h0);
        chk_i("reset_round_idx", int'(round_idx), 0);
        chk_i("reset_starts", int'({sub_start, shift_start, mix_start, ark_start}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven runs
        for (int v = 0; v < 5; v++) begin
            set_lat(vecs[v].ks, vecs[v].ksh, vecs[v].km, vecs[v].ka);
            run(vecs[v].pt, vecs[v].spur, vecs[v].pulse_at);
            chk_i($sformatf("v%0d_done_cycle", v), r_done_cyc, vecs[v].exp_cyc);
            chk_i($sformatf("v%0d_done_count", v), r_done_cnt, 1);
            chk_i($sformatf("v%0d_busy_after_done", v), int'(r_busy1), 0);
            chk_i($sformatf("v%0d_idle_after_done", v), int'(r_busy2), 0);
            chk_v($sformatf("v%0d_ct", v), ct, model(vecs[v].pt, 1'b0));
            chk_i($sformatf("v%0d_mix_in_last_round", v), int'(r_mix10), 0);
            chk_i($sformatf("v%0d_round_step", v), int'(r_rbad), 0);
            chk_i($sformatf("v%0d_round_max", v), r_max, 10);
            chk_i($sformatf("v%0d_sub_starts", v), r_starts[0], 10);
            chk_i($sformatf("v%0d_shift_starts", v), r_starts[1], 10);
            chk_i($sformatf("v%0d_mix_starts", v), r_starts[2], 9);
            chk_i($sformatf("v%0d_ark_starts", v), r_starts[3], 11);
        end

        // Known-answer test with real AES stages
        mode = 1'b1;
        set_lat(1, 1, 1, 1);
        run(128'h00112233445566778899aabbccddeeff, 1'b0, 0);
        chk_v("kat_ct", ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        chk_i("kat_done_cycle", r_done_cyc, 81);
        mode = 1'b0;

        // Start held high through FIN restarts on the following IDLE cycle
        p = 128'h55aa55aa0f0f0f0f3c3c3c3c96969696;
        d1 = -1; d2 = -1; dc = 0; b82 = 1'b1; b83 = 1'b0;
        start = 1'b1;
        pt = p;
        @(negedge clk);
        for (int n = 1; n <= 400; n++) begin
            if (done) begin
                dc++;
                if (d1 < 0) d1 = n; else if (d2 < 0) d2 = n;
            end
            if (n == 82) b82 = busy;
            if (n == 83) begin
                b83 = busy;
                start = 1'b0;
            end
            if (n >= 175) break;
            @(negedge clk);
        end
        start = 1'b0;
        chk_i("hold_first_done", d1, 81);
        chk_i("hold_idle_gap", int'(b82), 0);
        chk_i("hold_restart_busy", int'(b83), 1);
        chk_i("hold_second_done", d2, 163);
        chk_i("hold_done_count", dc, 2);
        chk_v("hold_ct", ct, model(p, 1'b0));

        // Asynchronous reset during round-5 MIX WAIT
        start = 1'b1;
        pt = 128'h13579bdf2468ace0fedcba9876543210;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int n = 1; n <= 500; n++) begin
            if (mix_start && round_idx == 4'd5) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk_i("reach_round5_mix", found, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_i("midrst_busy_done_err", int'({busy, done, err}), 0);
        chk_v("midrst_ct", ct, 128'h0);
        chk_i("midrst_round_idx", int'(round_idx), 0);
        chk_i("midrst_starts", int'({sub_start, shift_start, mix_start, ark_start}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(128'hfedcba98765432100123456789abcdef, 1'b0, 0);
        chk_i("post_rst_done_cycle", r_done_cyc, 81);
        chk_v("post_rst_ct", ct, model(128'hfedcba98765432100123456789abcdef, 1'b0));

`ifdef AES_CTRL_TIMEOUT_EN
        // Watchdog: ark_done never arrives in round 0
        begin
            int ark_n, err_n, err_c;
            bit b_after;
            ark_n = -1; err_n = -1; err_c = 0; dc = 0; b_after = 1'b1;
            set_lat(1, 1, 1, 0);
            p = 128'h0badf00d0badf00d0badf00d0badf00d;
            start = 1'b1;
            pt = p;
            @(negedge clk);
            start = 1'b0;
            for (int n = 1; n <= 80; n++) begin
                if (ark_start && ark_n < 0) ark_n = n;
                if (err) begin
                    err_c++;
                    if (err_n < 0) err_n = n;
                end
                if (done) dc++;
                if (err_n > 0 && n == err_n + 1) b_after = busy;
                @(negedge clk);
            end
            chk_i("wdog_ark_start", ark_n, 1);
            chk_i("wdog_err_cycle", err_n, 33);
            chk_i("wdog_err_count", err_c, 1);
            chk_i("wdog_no_done", dc, 0);
            chk_i("wdog_busy_falls", int'(b_after), 0);
            chk_v("wdog_ct_partial", ct, p);
            set_lat(1, 1, 1, 1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
